led_matrix_driver: RTL
======================

# led_matrix_driver

Row-scanning driver for the red/green LED matrix that shows the game field. It is the output end of the player interface, the counterpart of the key-input registering stage. It accepts a full frame from game logic through a valid/ack handshake and holds it in a shadow buffer. Frames swap only at frame boundaries, so a frame never tears. The driver multiplexes one row at a time onto the matrix pins, each row held for a fixed dwell time.

## Interface
- ROWS, 16, matrix rows
- COLS, 16, matrix columns
- DWELL, 1024, clk cycles each row is driven (≥2)
- BLANK, 4, blanking cycles after each row (used only with LED_BLANK_EN)
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- frame_red  in  ROWS*COLS  red pixels, bit [r*COLS+c] = row r, column c
- frame_grn  in  ROWS*COLS  green pixels, same indexing
- frame_valid  in  1  new frame offered; frame data stays stable until frame_ack
- frame_ack  out  1  one-cycle pulse: frame copied into shadow buffer
- row_sel  out  ROWS  one-hot active-high row drive, all-zero when dark
- red_out  out  COLS  active-high red column drive for the selected row
- grn_out  out  COLS  active-high green column drive for the selected row
- frame_start  out  1  one-cycle pulse in the first cycle row 0 is driven

## Operation
- States:
  - IDLE: dark, waiting for the first frame.
  - SCAN: driving row r.
  - BLANK: dark gap between rows; exists only with the macro.
- A pending flag is set when frame_valid=1 is sampled while no load happens in the same cycle.
- A load copies frame_red/frame_grn into the shadow buffer, pulses frame_ack and clears the pending flag.
- Loads occur only at frame boundaries:
  - IDLE exit, or
  - the transition from the last cycle of row ROWS-1 to row 0.
- At a boundary the load condition is pending OR frame_valid; it applies to that same edge.
- IDLE → SCAN row 0 on the edge after frame_valid=1 is sampled. Load happens on that edge.
- In SCAN:
  - row_sel = 1<<r.
  - red_out/grn_out = shadow row r.
  - The dwell counter runs 0..DWELL-1.
- At count DWELL-1:
  - Without the macro: r ← (r+1) mod ROWS and the counter clears.
  - With the macro: go to BLANK.
- Wrap-around ROWS-1 → 0 is a frame boundary and pulses frame_start. The scan continues with the old shadow if there is no load.
- Once any frame has loaded, the block never returns to IDLE except on reset.
- frame_valid held high continuously: one load per frame boundary, one ack per load.

## Timing
- Reset values: state IDLE, row_sel=0, red_out=0, grn_out=0, frame_ack=0, frame_start=0, r=0, counter=0, shadow=0, pending=0.
- Reset mid-scan goes dark on the next edge. A pending frame is discarded without an ack.
- All outputs are registered.
- Latency, frame_valid sampled high in IDLE at edge t:
  - at edge t+1: row_sel=1, frame_ack=1, frame_start=1, row 0 data.
  - ack is high for exactly one cycle.
- Row period is DWELL cycles without the macro, DWELL+BLANK with it.
- Frame period is ROWS × row period.
- Counter width is $clog2(DWELL+BLANK). Row index width is $clog2(ROWS).

## Configuration
- Macro: LED_BLANK_EN.
- Defined: after each row, BLANK cycles with row_sel=0, red_out=0, grn_out=0 (anti-ghosting). The next row (and any boundary load) starts after the BLANK cycles.
- Undefined: no BLANK state. Rows are back-to-back and the BLANK parameter is ignored.

## Structure
- Shared package flappy_pkg holds:
  - the constants MATRIX_ROWS and MATRIX_COLS used as parameter defaults;
  - typedef pixel_row_t (logic [MATRIX_COLS-1:0]);
  - the enum typedef for scan states.
- One natural sub-module, scan_timer: dwell/blank down-counter with a load and a terminal-count pulse.
- The FSM, shadow buffer and handshake stay in led_matrix_driver.

## Test plan
Bench uses ROWS=4, COLS=4, DWELL=3, BLANK=2.
- Reset, frame_valid=0 for 20 cycles → row_sel=0, red_out=0, grn_out=0, frame_ack=0 throughout.
- frame_red=16'h8421, frame_grn=0, valid for 1 cycle → next cycle ack=1, frame_start=1, row_sel=4'b0001, red_out=4'h1. Rows 1, 2, 3 follow with red_out=2, 4, 8, each held 3 cycles.
- Mid-frame valid pulse with frame_red=16'hFFFF → ack only at the first cycle of the next row 0; the current frame completes with the old data.
- Valid arriving exactly in the last cycle of row 3 → load on the same edge. Ack and frame_start coincide.
- Reset asserted during row 2 with a frame pending → dark next cycle, no ack, IDLE until a new valid.
- LED_BLANK_EN defined → 2 all-zero cycles between rows, frame period 20 cycles. Undefined → 12 cycles.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared player-interface types: matrix geometry defaults, pixel row type and
// LED scan FSM states.
package flappy_pkg;

  localparam int MATRIX_ROWS = 16;
  localparam int MATRIX_COLS = 16;

  typedef logic [MATRIX_COLS-1:0] pixel_row_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

endpackage

// File: rtl/led_matrix_driver_if.sv
// Frame handshake between game logic (master) and the LED matrix driver (slave).
interface led_matrix_driver_if
  import flappy_pkg::*;
#(
    parameter int ROWS = MATRIX_ROWS,
    parameter int COLS = MATRIX_COLS
);

    logic [ROWS*COLS-1:0] frame_red;
    logic [ROWS*COLS-1:0] frame_grn;
    logic                 frame_valid;
    logic                 frame_ack;

    modport master (output frame_red, frame_grn, frame_valid, input frame_ack);
    modport slave  (input frame_red, frame_grn, frame_valid, output frame_ack);

endinterface

// File: rtl/led_matrix_driver_scan_timer.sv
// Dwell/blank down-counter: load a cycle count minus one, tc marks the last
// cycle of the interval.
module scan_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = en && (cnt == '0);

endmodule

// File: rtl/led_matrix_driver.sv
// Row-scanning red/green LED matrix driver with tear-free shadow frame buffer.
// Define LED_BLANK_EN to insert BLANK dark cycles after every row.
module led_matrix_driver
  import flappy_pkg::*;
#(
    parameter int ROWS  = MATRIX_ROWS,
    parameter int COLS  = MATRIX_COLS,
    parameter int DWELL = 1024,
    parameter int BLANK = 4
) (
    input  logic              clk,
    input  logic              reset,
    led_matrix_driver_if.slave frm,
    output logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   red_out,
    output logic [COLS-1:0]   grn_out,
    output logic              frame_start
);

    localparam int CW = $clog2(DWELL + BLANK);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    scan_state_t          state;
    logic [RW-1:0]        r;
    logic [ROWS*COLS-1:0] shadow_red, shadow_grn;
    logic                 pending;
    logic                 ack_q;

    logic                 tc, tmr_load;
    logic [CW-1:0]        tmr_val;
    logic                 last_row, row_end, advance, do_load;
    logic [RW-1:0]        nxt_r;
    logic [ROWS*COLS-1:0] src_red, src_grn;

    scan_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (state != ST_IDLE),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tc)
    );

    always_comb begin
        last_row = (r == RW'(ROWS - 1));
`ifdef LED_BLANK_EN
        row_end  = (state == ST_BLANK) && tc;
`else
        row_end  = (state == ST_SCAN) && tc;
`endif
        advance  = ((state == ST_IDLE) && frm.frame_valid) || row_end;
        nxt_r    = ((state == ST_IDLE) || last_row) ? '0 : r + 1'b1;
        // Every entry into row 0 is a frame boundary; only there may the shadow change.
        do_load  = advance && (nxt_r == '0) && (pending || frm.frame_valid);
        src_red  = do_load ? frm.frame_red : shadow_red;
        src_grn  = do_load ? frm.frame_grn : shadow_grn;
        tmr_load = advance;
        tmr_val  = CW'(DWELL - 1);
`ifdef LED_BLANK_EN
        if ((state == ST_SCAN) && tc) begin
            tmr_load = 1'b1;
            tmr_val  = CW'(BLANK - 1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            r           <= '0;
            shadow_red  <= '0;
            shadow_grn  <= '0;
            pending     <= 1'b0;
            ack_q       <= 1'b0;
            row_sel     <= '0;
            red_out     <= '0;
            grn_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            ack_q       <= do_load;
            frame_start <= advance && (nxt_r == '0);
            if (do_load) begin
                shadow_red <= frm.frame_red;
                shadow_grn <= frm.frame_grn;
                pending    <= 1'b0;
            end else if (frm.frame_valid) begin
                pending    <= 1'b1;
            end

            if (advance) begin
                state   <= ST_SCAN;
                r       <= nxt_r;
                row_sel <= ROWS'(1) << nxt_r;
                red_out <= src_red[int'(nxt_r)*COLS +: COLS];
                grn_out <= src_grn[int'(nxt_r)*COLS +: COLS];
            end
`ifdef LED_BLANK_EN
            else if ((state == ST_SCAN) && tc) begin
                state   <= ST_BLANK;
                row_sel <= '0;
                red_out <= '0;
                grn_out <= '0;
            end
`endif
        end
    end

    assign frm.frame_ack = ack_q;

endmodule
